// File: rtl/mm_pkg.sv
// Shared definitions for the systolic multiplier operand address path.
// Contents:
//   addr_gen_state_t : states of the tile address generator FSM
//   ceil_div         : integer ceiling division, used to count the column
//                      slices and row bands of a matrix
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        NEXT_COL,
        FINISH
    } addr_gen_state_t;

    // The arguments are 32 bits wide so that num + den - 1 cannot overflow
    // for the 16-bit dimensions used by this block.
    function automatic logic [31:0] ceil_div(input logic [31:0] num,
                                             input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/addr_gen_loop_counter.sv
// Loop counter for the address generator. It is cleared to zero, counts up
// by one, and flags the iteration whose count equals last_value.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : synchronous return to zero (wins over incr)
//   incr         : advance by one
//   last_value   : index of the final iteration (iterations - 1)
//   tc           : high while the counter sits on its final iteration
module addr_gen_loop_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             incr,
    input  logic [WIDTH-1:0] last_value,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (incr) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign tc = (count_reg == last_value);

endmodule

// File: rtl/mem_tile_addresses_generator.sv
// Read-address generator for one operand matrix of the systolic multiplier.
// It walks a row-major matrix band by band (TILE_ROWS rows per band). For
// every bus-wide column slice it emits one address per row of the band, and
// it replays each band "passes" times before it moves to the next band.
// Ports:
//   clk, reset_n  : clock and asynchronous active-low reset
//   start_i       : start pulse, honoured only while idle
//   m, n          : matrix rows / columns (elements)
//   base_addr     : byte address of element (0,0)
//   row_pitch     : bytes between rows, 0 selects n*DATA_WIDTH_BYTES
//   passes        : replays per band, 0 behaves as 1
//   addr_o        : address towards the operand FIFO
//   addr_valid_o  : addr_o valid (valid/ready handshake)
//   addr_ready_i  : FIFO can accept
//   busy_o        : operation in progress
//   done_o        : one-cycle pulse once every address has been accepted
module mem_tile_addresses_generator
    import mm_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int DIM_WIDTH        = 16,
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int TILE_ROWS        = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [DIM_WIDTH-1:0]  m,
    input  logic [DIM_WIDTH-1:0]  n,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_pitch,
    input  logic [DIM_WIDTH-1:0]  passes,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int ELEMENTS   = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
    localparam int DATA_SHIFT = $clog2(DATA_WIDTH_BYTES);
    localparam int TILE_SHIFT = $clog2(TILE_ROWS);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP    = ADDR_WIDTH'(BUS_WIDTH_BYTES);
    localparam logic [DIM_WIDTH-1:0]  TILE_ROWS_D = DIM_WIDTH'(TILE_ROWS);

    addr_gen_state_t state_reg, state_next;

    // Latched job description
    logic [ADDR_WIDTH-1:0] base_reg, pitch_reg;
    logic [DIM_WIDTH-1:0]  col_last_reg, pass_last_reg, band_last_reg;
    logic                  empty_reg;
    // Rows not yet covered by completed bands; sizes the current band
    logic [DIM_WIDTH-1:0]  rows_left_reg;

    // Address walkers: current address, first address of the band, and
    // first address of the current column slice within the band
    logic [ADDR_WIDTH-1:0] addr_reg, band_start_reg, col_start_reg;

    logic [DIM_WIDTH-1:0]  rows_in_band, row_last;
    logic                  start_accept, emit_hs, in_next_col;
    logic                  row_tc, col_tc, pass_tc, band_tc;

    assign start_accept = (state_reg == IDLE) && start_i;
    assign emit_hs      = (state_reg == EMIT) && addr_ready_i;
    assign in_next_col  = (state_reg == NEXT_COL);

    // Last band may be short when m is not a multiple of TILE_ROWS
    assign rows_in_band = (rows_left_reg >= TILE_ROWS_D) ? TILE_ROWS_D : rows_left_reg;
    assign row_last     = rows_in_band - DIM_WIDTH'(1);

    addr_gen_loop_counter #(.WIDTH(DIM_WIDTH)) u_row_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_accept || (emit_hs && row_tc)),
        .incr       (emit_hs),
        .last_value (row_last),
        .tc         (row_tc)
    );

    addr_gen_loop_counter #(.WIDTH(DIM_WIDTH)) u_col_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_accept || (in_next_col && col_tc)),
        .incr       (in_next_col && !col_tc),
        .last_value (col_last_reg),
        .tc         (col_tc)
    );

    addr_gen_loop_counter #(.WIDTH(DIM_WIDTH)) u_pass_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_accept || (in_next_col && col_tc && pass_tc)),
        .incr       (in_next_col && col_tc && !pass_tc),
        .last_value (pass_last_reg),
        .tc         (pass_tc)
    );

    addr_gen_loop_counter #(.WIDTH(DIM_WIDTH)) u_band_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_accept),
        .incr       (in_next_col && col_tc && pass_tc && !band_tc),
        .last_value (band_last_reg),
        .tc         (band_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_valid_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy_o     = 1'b1;
                state_next = empty_reg ? FINISH : EMIT;
            end
            EMIT: begin
                busy_o       = 1'b1;
                addr_valid_o = 1'b1;
                if (addr_ready_i && row_tc) begin
                    state_next = NEXT_COL;
                end
            end
            NEXT_COL: begin
                busy_o     = 1'b1;
                state_next = (col_tc && pass_tc && band_tc) ? FINISH : EMIT;
            end
            FINISH: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg       <= '0;
            band_start_reg <= '0;
            col_start_reg  <= '0;
            base_reg       <= '0;
            pitch_reg      <= '0;
            col_last_reg   <= '0;
            pass_last_reg  <= '0;
            band_last_reg  <= '0;
            rows_left_reg  <= '0;
            empty_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        base_reg      <= base_addr;
                        pitch_reg     <= (row_pitch == '0) ? (ADDR_WIDTH'(n) << DATA_SHIFT)
                                                           : row_pitch;
                        col_last_reg  <= DIM_WIDTH'(ceil_div(32'(n), 32'(ELEMENTS)) - 32'd1);
                        band_last_reg <= DIM_WIDTH'(ceil_div(32'(m), 32'(TILE_ROWS)) - 32'd1);
                        pass_last_reg <= (passes == '0) ? '0 : passes - DIM_WIDTH'(1);
                        rows_left_reg <= m;
                        empty_reg     <= (m == '0) || (n == '0);
                    end
                end
                LOAD: begin
                    addr_reg       <= base_reg;
                    band_start_reg <= base_reg;
                    col_start_reg  <= base_reg;
                end
                EMIT: begin
                    // The last row leaves addr_reg alone; NEXT_COL rewrites it
                    if (addr_ready_i && !row_tc) begin
                        addr_reg <= addr_reg + pitch_reg;
                    end
                end
                NEXT_COL: begin
                    if (!col_tc) begin
                        col_start_reg <= col_start_reg + COL_STEP;
                        addr_reg      <= col_start_reg + COL_STEP;
                    end else if (!pass_tc) begin
                        col_start_reg <= band_start_reg;
                        addr_reg      <= band_start_reg;
                    end else if (!band_tc) begin
                        band_start_reg <= band_start_reg + (pitch_reg << TILE_SHIFT);
                        col_start_reg  <= band_start_reg + (pitch_reg << TILE_SHIFT);
                        addr_reg       <= band_start_reg + (pitch_reg << TILE_SHIFT);
                        rows_left_reg  <= rows_left_reg - TILE_ROWS_D;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign addr_o = addr_reg;

endmodule
